// File: rtl/fifo_ctrl_if.sv
// Producer/consumer side of the FIFO controller: push/pop handshake, read data and status.
interface fifo_ctrl_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 7
);
    logic          push;
    logic [DW-1:0] din;
    logic          pop;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    modport master (
        output push, din, pop,
        input  dout, dout_valid, full, empty, almost_full, count, overflow, underflow
    );

    modport slave (
        input  push, din, pop,
        output dout, dout_valid, full, empty, almost_full, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_ctrl.sv
// FIFO controller wrapping a 2**AW x DW dual-port RAM: port 1 writes at wr_ptr, port 2 reads at rd_ptr.
// Owns pointers, occupancy count, registered read data and sticky overflow/underflow flags.
module fifo_ctrl #(
    parameter int unsigned DW       = 8,
    parameter int unsigned AW       = 7,
    parameter int unsigned AF_LEVEL = 120
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    fifo_ctrl_if.slave    bus,
    output logic [AW-1:0] ram_a1,
    output logic [DW-1:0] ram_d1,
    output logic          ram_we1,
    output logic [AW-1:0] ram_a2,
    output logic          ram_we2,
    input  logic [DW-1:0] ram_q2
);
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned DEPTH = 1 << AW;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          overflow;
    logic          underflow;
    logic          full;
    logic          empty;
    logic          flush;
    logic          push_ok;
    logic          pop_ok;

    // Status decoded from the registered count, so it only moves after an edge.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign flush   = ~rst_n | clear;
    assign push_ok = bus.push & ~full & ~flush;
    assign pop_ok  = bus.pop & ~empty & ~flush;

    assign ram_a1  = wr_ptr;
    assign ram_d1  = bus.din;
    assign ram_we1 = push_ok;
    assign ram_a2  = rd_ptr;
    assign ram_we2 = 1'b0;

    assign bus.dout        = dout;
    assign bus.dout_valid  = dout_valid;
    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.almost_full = (count >= CW'(AF_LEVEL));
    assign bus.count       = count;
    assign bus.overflow    = overflow;
    assign bus.underflow   = underflow;

    // Simultaneous accepted push and pop leave occupancy unchanged.
    always_comb begin
        count_nxt = count;
        case ({push_ok, pop_ok})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            count      <= count_nxt;
            dout_valid <= pop_ok;
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
                dout   <= ram_q2;
            end
            if (bus.push && full) begin
                overflow <= 1'b1;
            end
            if (bus.pop && empty) begin
                underflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: behavioural RAM plus a queue-based reference FIFO.
module tb_fifo_ctrl;
    logic       clk;
    logic       rst_n;
    logic       clear;
    logic [6:0] ram_a1;
    logic [7:0] ram_d1;
    logic       ram_we1;
    logic [6:0] ram_a2;
    logic       ram_we2;
    logic [7:0] ram_q2;
    logic [7:0] mem [128];

    fifo_ctrl_if #(.DW(8), .AW(7)) bus ();

    fifo_ctrl #(.DW(8), .AW(7), .AF_LEVEL(120)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .bus     (bus),
        .ram_a1  (ram_a1),
        .ram_d1  (ram_d1),
        .ram_we1 (ram_we1),
        .ram_a2  (ram_a2),
        .ram_we2 (ram_we2),
        .ram_q2  (ram_q2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (ram_we1) mem[ram_a1] <= ram_d1;
    assign ram_q2 = mem[ram_a2];

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [7:0] exp_q[$];
    logic [7:0] exp_dout = 8'h00;
    logic       exp_dv = 1'b0;
    logic       exp_of = 1'b0;
    logic       exp_uf = 1'b0;
    int         exp_wa = 0;
    int         exp_ra = 0;

    // One clock: drive inputs, check the combinational write enable, advance DUT and model.
    task automatic step(input logic p, input logic [7:0] d, input logic q,
                        input logic c, input logic r);
        logic we_exp;
        logic is_full;
        logic is_empty;
        bus.push = p; bus.din = d; bus.pop = q; clear = c; rst_n = r;
        #1;
        is_full  = (exp_q.size() == 128);
        is_empty = (exp_q.size() == 0);
        we_exp   = r && !c && p && !is_full;
        vectors++;
        if (ram_we1 !== we_exp) begin
            miscompares++;
            $display("FAIL ram_we1: got %b expected %b", ram_we1, we_exp);
        end
        @(posedge clk);
        if (!r || c) begin
            exp_q.delete();
            exp_dout = 8'h00; exp_dv = 1'b0; exp_of = 1'b0; exp_uf = 1'b0;
            exp_wa = 0; exp_ra = 0;
        end else begin
            exp_dv = q && !is_empty;
            if (exp_dv) begin
                exp_dout = exp_q.pop_front();
                exp_ra = (exp_ra + 1) % 128;
            end
            if (p && !is_full) begin
                exp_q.push_back(d);
                exp_wa = (exp_wa + 1) % 128;
            end
            if (p && is_full) exp_of = 1'b1;
            if (q && is_empty) exp_uf = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        vectors++; if (bus.count !== 8'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
        vectors++; if (bus.empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b expected 1", bus.empty); end
        vectors++; if ({bus.full, bus.almost_full, bus.overflow, bus.underflow, bus.dout_valid} !== 5'b0) begin
            miscompares++; $display("FAIL reset_flags: got %b expected 00000",
                {bus.full, bus.almost_full, bus.overflow, bus.underflow, bus.dout_valid});
        end
        vectors++; if (bus.dout !== 8'h00) begin miscompares++; $display("FAIL reset_dout: got %0h expected 0", bus.dout); end
        vectors++; if ({ram_a1, ram_a2, ram_we2} !== 15'b0) begin
            miscompares++; $display("FAIL reset_ram: a1 %0d a2 %0d we2 %b expected 0", ram_a1, ram_a2, ram_we2);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 128; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
            vectors++; if (bus.count !== 8'(i + 1)) begin miscompares++; $display("FAIL fill_count: got %0d expected %0d", bus.count, i + 1); end
            vectors++; if (bus.almost_full !== (i + 1 >= 120)) begin miscompares++; $display("FAIL fill_af at %0d: got %b", i + 1, bus.almost_full); end
            vectors++; if (bus.full !== (i + 1 == 128)) begin miscompares++; $display("FAIL fill_full at %0d: got %b", i + 1, bus.full); end
        end
        for (int i = 0; i < 128; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
            vectors++; if (bus.dout_valid !== 1'b1) begin miscompares++; $display("FAIL drain_valid: got %b expected 1", bus.dout_valid); end
            vectors++; if (bus.dout !== 8'(i)) begin miscompares++; $display("FAIL drain_data: got %0h expected %0h", bus.dout, 8'(i)); end
        end
        vectors++; if (bus.empty !== 1'b1) begin miscompares++; $display("FAIL drain_empty: got %b expected 1", bus.empty); end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        vectors++; if (bus.dout_valid !== 1'b0 || bus.dout !== 8'd127) begin
            miscompares++; $display("FAIL dout_hold: valid %b dout %0h expected 0/7f", bus.dout_valid, bus.dout);
        end
    endtask

    task automatic test_wrap();
        int base;
        base = 0;
        for (int blk = 0; blk < 2; blk++) begin
            int n;
            n = (blk == 0) ? 100 : 60;
            for (int i = 0; i < n; i++) step(1'b1, 8'(base + i + 16), 1'b0, 1'b0, 1'b1);
            for (int i = 0; i < n; i++) begin
                step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
                vectors++; if (bus.dout !== 8'(base + i + 16) || bus.dout_valid !== 1'b1) begin
                    miscompares++; $display("FAIL wrap_data: got %0h/%b expected %0h/1", bus.dout, bus.dout_valid, 8'(base + i + 16));
                end
            end
            base = base + n;
        end
        vectors++; if (bus.count !== 8'd0 || ram_a2 !== 7'd32) begin
            miscompares++; $display("FAIL wrap_end: count %0d rd %0d expected 0/32", bus.count, ram_a2);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b1);
            vectors++; if (bus.count !== 8'd5) begin miscompares++; $display("FAIL sim_count: got %0d expected 5", bus.count); end
            vectors++; if (bus.dout !== exp_dout) begin miscompares++; $display("FAIL sim_data: got %0h expected %0h", bus.dout, exp_dout); end
        end
        while (exp_q.size() < 128) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
        vectors++; if (bus.count !== 8'd127 || bus.overflow !== 1'b1 || bus.dout_valid !== 1'b1) begin
            miscompares++; $display("FAIL full_pushpop: count %0d of %b dv %b expected 127/1/1", bus.count, bus.overflow, bus.dout_valid);
        end
        while (exp_q.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        step(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1);
        vectors++; if (bus.count !== 8'd1 || bus.underflow !== 1'b1 || bus.dout_valid !== 1'b0) begin
            miscompares++; $display("FAIL empty_pushpop: count %0d uf %b dv %b expected 1/1/0", bus.count, bus.underflow, bus.dout_valid);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        vectors++; if (bus.dout !== 8'h3C) begin miscompares++; $display("FAIL empty_pushpop_data: got %0h expected 3c", bus.dout); end
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_errors_clear();
        logic [6:0] rd_before;
        rd_before = ram_a2;
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        vectors++; if (bus.underflow !== 1'b1 || ram_a2 !== rd_before || bus.dout_valid !== 1'b0) begin
            miscompares++; $display("FAIL underflow: uf %b rd %0d dv %b expected 1/%0d/0", bus.underflow, ram_a2, bus.dout_valid, rd_before);
        end
        for (int i = 0; i < 40; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h11, 1'b1, 1'b0, 1'b1);
        vectors++; if (bus.underflow !== 1'b1 || bus.count !== 8'd40) begin
            miscompares++; $display("FAIL uf_sticky: uf %b count %0d expected 1/40", bus.underflow, bus.count);
        end
        step(1'b1, 8'h22, 1'b0, 1'b1, 1'b1);
        vectors++; if (bus.count !== 8'd0 || bus.empty !== 1'b1 || bus.underflow !== 1'b0 || bus.overflow !== 1'b0) begin
            miscompares++; $display("FAIL clear: count %0d empty %b uf %b of %b expected 0/1/0/0", bus.count, bus.empty, bus.underflow, bus.overflow);
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 50; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        step(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
        vectors++; if (bus.count !== 8'd0 || bus.dout !== 8'h00 || bus.dout_valid !== 1'b0) begin
            miscompares++; $display("FAIL mid_reset: count %0d dout %0h dv %b expected 0/0/0", bus.count, bus.dout, bus.dout_valid);
        end
        step(1'b1, 8'h5C, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        vectors++; if (bus.dout !== 8'h5C || bus.dout_valid !== 1'b1) begin
            miscompares++; $display("FAIL mid_reset_data: got %0h/%b expected 5c/1", bus.dout, bus.dout_valid);
        end
    endtask

    task automatic test_random();
        int push_pct;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) push_pct = $urandom_range(20, 85);
            step(($urandom_range(0, 99) < push_pct), 8'($urandom),
                 ($urandom_range(0, 99) >= push_pct - 5), ($urandom_range(0, 299) == 0), 1'b1);
            vectors++; if (bus.count !== 8'(exp_q.size())) begin miscompares++; $display("FAIL rnd_count: got %0d expected %0d", bus.count, exp_q.size()); end
            vectors++; if (bus.dout !== exp_dout || bus.dout_valid !== exp_dv) begin
                miscompares++; $display("FAIL rnd_dout: got %0h/%b expected %0h/%b", bus.dout, bus.dout_valid, exp_dout, exp_dv);
            end
            vectors++; if (bus.full !== (exp_q.size() == 128) || bus.empty !== (exp_q.size() == 0) || bus.almost_full !== (exp_q.size() >= 120)) begin
                miscompares++; $display("FAIL rnd_status: full %b empty %b af %b at size %0d", bus.full, bus.empty, bus.almost_full, exp_q.size());
            end
            vectors++; if (bus.overflow !== exp_of || bus.underflow !== exp_uf) begin
                miscompares++; $display("FAIL rnd_sticky: of %b uf %b expected %b %b", bus.overflow, bus.underflow, exp_of, exp_uf);
            end
            vectors++; if (ram_a1 !== 7'(exp_wa) || ram_a2 !== 7'(exp_ra)) begin
                miscompares++; $display("FAIL rnd_ptr: a1 %0d a2 %0d expected %0d %0d", ram_a1, ram_a2, exp_wa, exp_ra);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0;
        bus.push = 1'b0; bus.din = 8'h00; bus.pop = 1'b0;
        test_reset();
        test_fill_drain();
        test_wrap();
        test_simultaneous();
        test_errors_clear();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
